demux_1ton_stream: RTL and testbench
====================================

Name: demux_1ton_stream

Overview:
- Parametrised, registered successor to the 1-to-4 dataflow demultiplexer.
- Routes one valid/ready input stream to one of N_CH output streams.
- Each output channel has its own 1-entry output register.
- Two routing modes: explicit select, or round-robin distribution.
- Out-of-range selects are dropped, flagged and counted.
- Sits between a single producer and N independent consumers.

Parameters:
- DATA_W, 8: payload width in bits.
- N_CH, 4: number of output channels, 2..16.
- SEL_W, $clog2(N_CH): select and pointer width.
- CNT_W, 8: drop counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = route by in_sel; 1 = round-robin.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input can accept this cycle.
- in_data  in  DATA_W  input payload.
- in_sel  in  SEL_W  target channel; used only when mode = 0.
- out_valid  out  N_CH  per-channel valid.
- out_ready  in  N_CH  per-channel ready.
- out_data  out  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- err_clr  in  1  synchronous clear of err_sel and drop_cnt.
- err_sel  out  1  sticky; set when a beat is dropped.
- drop_cnt  out  CNT_W  number of dropped beats, saturating.
- rr_ptr  out  SEL_W  current round-robin target.

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 0; out_data = 0; rr_ptr = 0; err_sel = 0; drop_cnt = 0.
  - in_ready is low while rst_n = 0.
- Target selection:
  - tgt = in_sel when mode = 0; tgt = rr_ptr when mode = 1.
  - Mode is sampled every cycle. A mode change takes effect on the next accepted beat. rr_ptr is retained across mode changes.
- in_ready (combinational from state and out_ready; never from in_valid):
  - If tgt >= N_CH (possible only when mode = 0): in_ready = 1.
  - Otherwise: in_ready = !out_valid[tgt] | out_ready[tgt].
- Accept = in_valid & in_ready.
- Latency: an accepted beat appears on out_valid[tgt]/out_data[tgt] the next cycle.
- Channel register k:
  - Load when accept & tgt == k: out_data[k] <= in_data; out_valid[k] <= 1.
  - Else, if out_valid[k] & out_ready[k]: out_valid[k] <= 0; out_data[k] holds its value.
  - Load and drain in the same cycle: the new beat is loaded and valid stays 1. This gives full throughput of 1 beat/cycle per channel.
  - Other channels are unaffected by an accept. Each channel drains independently.
- Stability: while out_valid[k] = 1 and out_ready[k] = 0, out_data[k] is held.
- Drop path (accept with tgt >= N_CH):
  - No channel is loaded.
  - err_sel <= 1.
  - drop_cnt increments, saturating at 2^CNT_W-1.
- err_clr:
  - Clears err_sel and drop_cnt.
  - If a drop happens in the same cycle, err_clr wins: the result is 0/0.
- Round-robin:
  - On each accept in mode = 1: rr_ptr <= (rr_ptr == N_CH-1) ? 0 : rr_ptr+1.
  - No advance without an accept. A stalled target blocks the input; no skipping to a free channel.
- Non-power-of-two N_CH: rr_ptr never exceeds N_CH-1. Select codes >= N_CH are out of range.
- Reset mid-operation: all held beats are discarded. No partial state survives.
- No combinational path from in_valid/in_data to outputs. All outputs are registered except in_ready.

Test Plan:
- Reset, then mode = 0 with in_sel = 2, in_data = 0xA5, one beat, all out_ready = 1 → next cycle out_valid = 4'b0100, out_data[2] = 0xA5. Cycle after: out_valid = 0.
- mode = 0, sel = 1, out_ready[1] = 0, send 0x11 then 0x22 → 0x11 held on ch1, in_ready = 0 for the second beat. Raise out_ready[1] → 0x11 drains; 0x22 is accepted that same cycle and appears next.
- mode = 1, N_CH = 4, 6 back-to-back beats 0..5, all ready → beats land on ch 0,1,2,3,0,1. rr_ptr ends at 2. 1 beat/cycle sustained.
- N_CH = 3, mode = 0, in_sel = 3, three beats → in_ready = 1, no out_valid. err_sel = 1, drop_cnt = 3. Then err_clr together with one more drop → err_sel = 0, drop_cnt = 0.
- CNT_W = 2, five drops → drop_cnt saturates at 3.
- Load ch0 and ch3, then assert rst_n = 0 mid-stall → out_valid = 0 immediately (async). After release, rr_ptr = 0 and in_ready = 1.

Source files
------------

// File: rtl/demux_1ton_stream.sv
// demux_1ton_stream
//   Routes one valid/ready input stream to one of N_CH output streams.
//   Each output channel owns a 1-entry register, so every channel sustains
//   one beat per cycle and drains independently of the others.
//   Routing is either by explicit select (mode = 0) or round-robin (mode = 1).
//   Beats addressed to a non-existent channel are accepted, dropped, flagged
//   and counted.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   mode           0 = route by in_sel, 1 = round-robin via rr_ptr
//   in_valid/in_ready/in_data/in_sel   input stream
//   out_valid/out_ready/out_data       per-channel output streams;
//                                      channel k at out_data[k*DATA_W +: DATA_W]
//   err_clr        synchronous clear of err_sel and drop_cnt
//   err_sel        sticky drop flag
//   drop_cnt       saturating count of dropped beats
//   rr_ptr         current round-robin target
module demux_1ton_stream #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  input  logic                     err_clr,
  output logic                     err_sel,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [SEL_W-1:0]         rr_ptr
);

  logic [N_CH-1:0]        out_valid_q, out_valid_d;
  logic [N_CH*DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]       rr_ptr_q,    rr_ptr_d;
  logic                   err_sel_q,   err_sel_d;
  logic [CNT_W-1:0]       drop_cnt_q,  drop_cnt_d;

  logic [SEL_W-1:0] tgt;
  logic [N_CH-1:0]  tgt_oh;
  logic             tgt_ok;
  logic             accept;
  logic             drop;

  assign tgt = mode ? rr_ptr_q : in_sel;

  // One-hot decode of the target. Codes with no matching channel leave the
  // vector zero, which is how out-of-range selects are detected without a
  // magnitude compare that would be constant for power-of-two N_CH.
  always_comb begin
    tgt_oh = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (tgt == SEL_W'(k)) tgt_oh[k] = 1'b1;
    end
  end

  assign tgt_ok = |tgt_oh;

  // Out-of-range beats are always accepted so they can be dropped.
  // Gating with rst_n keeps the producer stalled while reset is held.
  assign in_ready = rst_n & (~tgt_ok | (|(tgt_oh & (~out_valid_q | out_ready))));
  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~tgt_ok;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int k = 0; k < N_CH; k++) begin
      if (accept && tgt_oh[k]) begin
        // A load in the same cycle as a drain keeps valid high.
        out_valid_d[k]                  = 1'b1;
        out_data_d[k*DATA_W +: DATA_W]  = in_data;
      end else if (out_valid_q[k] && out_ready[k]) begin
        out_valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && mode) begin
      if (rr_ptr_q == SEL_W'(N_CH - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = rr_ptr_q + SEL_W'(1);
    end
  end

  always_comb begin
    err_sel_d  = err_sel_q;
    drop_cnt_d = drop_cnt_q;
    if (err_clr) begin
      err_sel_d  = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      err_sel_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      err_sel_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      err_sel_q   <= err_sel_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rr_ptr    = rr_ptr_q;
  assign err_sel   = err_sel_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_1ton_stream.sv
module tb_demux_1ton_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N_CH = 4, CNT_W = 8
  logic        a_mode, a_in_valid, a_in_ready, a_err_clr, a_err_sel;
  logic [7:0]  a_in_data;
  logic [1:0]  a_in_sel, a_rr_ptr;
  logic [3:0]  a_out_valid, a_out_ready;
  logic [31:0] a_out_data;
  logic [7:0]  a_drop_cnt;

  // Instance B: N_CH = 3 (select code 3 is out of range), CNT_W = 2
  logic        b_mode, b_in_valid, b_in_ready, b_err_clr, b_err_sel;
  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel, b_rr_ptr;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [23:0] b_out_data;
  logic [1:0]  b_drop_cnt;

  demux_1ton_stream #(.DATA_W(8), .N_CH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .in_sel(a_in_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .err_clr(a_err_clr), .err_sel(a_err_sel), .drop_cnt(a_drop_cnt),
    .rr_ptr(a_rr_ptr)
  );

  demux_1ton_stream #(.DATA_W(8), .N_CH(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .err_clr(b_err_clr), .err_sel(b_err_sel), .drop_cnt(b_drop_cnt),
    .rr_ptr(b_rr_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_mode = 0; a_in_valid = 0; a_in_data = 0; a_in_sel = 0; a_out_ready = 0; a_err_clr = 0;
    b_mode = 0; b_in_valid = 0; b_in_data = 0; b_in_sel = 0; b_out_ready = 0; b_err_clr = 0;
    #2;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_rr_ptr", a_rr_ptr, 0);
    chk("rst_err_sel", a_err_sel, 0);
    chk("rst_drop_cnt", a_drop_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", a_in_ready, 1);

    // Single beat to channel 2
    a_out_ready = 4'hF; a_in_sel = 2; a_in_data = 8'hA5; a_in_valid = 1;
    #1;
    chk("t1_in_ready", a_in_ready, 1);
    step();
    a_in_valid = 0;
    chk("t1_out_valid", a_out_valid, 4'b0100);
    chk("t1_out_data2", a_out_data[23:16], 8'hA5);
    step();
    chk("t1_drained", a_out_valid, 4'b0000);

    // Backpressure on channel 1
    a_out_ready = 4'b1101; a_in_sel = 1; a_in_data = 8'h11; a_in_valid = 1;
    step();
    a_in_data = 8'h22;
    #1;
    chk("t2_hold_valid", a_out_valid, 4'b0010);
    chk("t2_hold_data", a_out_data[15:8], 8'h11);
    chk("t2_in_ready_lo", a_in_ready, 0);
    step();
    chk("t2_still_held", a_out_data[15:8], 8'h11);
    chk("t2_in_ready_lo2", a_in_ready, 0);
    a_out_ready = 4'hF;
    #1;
    chk("t2_in_ready_hi", a_in_ready, 1);
    step();
    a_in_valid = 0;
    chk("t2_new_valid", a_out_valid, 4'b0010);
    chk("t2_new_data", a_out_data[15:8], 8'h22);
    step();
    chk("t2_drained", a_out_valid, 4'b0000);

    // Round-robin, 6 back-to-back beats: channels 0,1,2,3,0,1
    a_mode = 1; a_in_sel = 3; a_in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      a_in_data = 8'(i);
      #1;
      chk("t3_rr_ptr", a_rr_ptr, i % 4);
      chk("t3_in_ready", a_in_ready, 1);
      step();
      chk("t3_out_valid", a_out_valid, 32'(1) << (i % 4));
      chk("t3_out_data", (a_out_data >> ((i % 4) * 8)) & 32'hFF, i);
    end
    a_in_valid = 0;
    #1;
    chk("t3_rr_end", a_rr_ptr, 2);
    chk("t3_no_drop", a_drop_cnt, 0);
    step();

    // rr_ptr retained across mode change
    a_mode = 0; a_in_sel = 3; a_in_data = 8'h77; a_in_valid = 1;
    step();
    a_in_valid = 0;
    chk("t4_ch3", a_out_valid, 4'b1000);
    chk("t4_ch3_data", a_out_data[31:24], 8'h77);
    chk("t4_rr_kept", a_rr_ptr, 2);
    step();

    // Load ch0 and ch3 under stall, then reset mid-stall
    a_out_ready = 4'h0; a_in_sel = 0; a_in_data = 8'hC0; a_in_valid = 1;
    step();
    a_in_sel = 3; a_in_data = 8'hC3;
    step();
    a_in_valid = 0;
    chk("t5_loaded", a_out_valid, 4'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", a_out_valid, 0);
    chk("t5_async_data", a_out_data, 0);
    chk("t5_in_ready_rst", a_in_ready, 0);
    step();
    rst_n = 1'b1;
    a_mode = 1;
    #1;
    chk("t5_rr_zero", a_rr_ptr, 0);
    chk("t5_in_ready", a_in_ready, 1);

    // N_CH = 3: out-of-range drops
    b_mode = 0; b_in_sel = 3; b_in_data = 8'hEE; b_out_ready = 3'b111; b_in_valid = 1;
    #1;
    chk("b_drop_in_ready", b_in_ready, 1);
    step();
    chk("b_drop1_cnt", b_drop_cnt, 1);
    chk("b_drop1_err", b_err_sel, 1);
    chk("b_drop1_nov", b_out_valid, 0);
    step();
    chk("b_drop2_cnt", b_drop_cnt, 2);
    step();
    chk("b_drop3_cnt", b_drop_cnt, 3);
    chk("b_drop3_nov", b_out_valid, 0);
    b_err_clr = 1;
    step();
    b_err_clr = 0;
    chk("b_clr_wins_err", b_err_sel, 0);
    chk("b_clr_wins_cnt", b_drop_cnt, 0);
    // Five drops into a 2-bit counter: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b_sat_cnt", b_drop_cnt, (i < 3) ? i + 1 : 3);
    end
    b_in_valid = 0;
    b_err_clr = 1;
    step();
    b_err_clr = 0;
    chk("b_clr_cnt", b_drop_cnt, 0);
    chk("b_clr_err", b_err_sel, 0);

    // Round-robin wraps at N_CH-1 = 2; in_sel ignored in mode 1
    b_mode = 1; b_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_in_data = 8'h40 + 8'(i);
      #1;
      chk("b_rr_ptr", b_rr_ptr, i % 3);
      step();
      chk("b_rr_valid", b_out_valid, 32'(1) << (i % 3));
      chk("b_rr_data", (b_out_data >> ((i % 3) * 8)) & 32'hFF, 32'h40 + i);
    end
    b_in_valid = 0;
    #1;
    chk("b_rr_end", b_rr_ptr, 1);
    chk("b_rr_no_drop", b_drop_cnt, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
